mac_array_seq: RTL and testbench

- Sequencer for a DIM x DIM systolic array of tpumac cells.
- One start pulse triggers a full matrix multiply:
  - clears every cell's accumulator through the WrEn path (datapath drives Cin=0);
  - steps a skewed feed schedule so the external skew/buffer logic drives A rows and B columns into the array edge;
  - drains C one row per cycle.
- Sits between the top-level command logic and the array/operand buffers. It owns mac_en and mac_wren for every cell.

---
 rtl/mac_array_seq.sv | 146 ++++++++++++++
 tb/tb_mac_array_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_seq.sv
// Sequencer for a DIM x DIM systolic tpumac array: clears the accumulators, steps a skewed
// operand feed schedule, then drains C one row per cycle.
module mac_array_seq #(
   parameter int DIM = 8,
   parameter int TW  = $clog2(3*DIM-1),
   parameter int RW  = $clog2(DIM)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           hold,
   output logic           busy,
   output logic           done,
   output logic           mac_en,
   output logic           mac_wren,
   output logic [TW-1:0]  feed_t,
   output logic [DIM-1:0] feed_mask,
   output logic [RW-1:0]  c_rd_row,
   output logic           c_rd_valid
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      FEED  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [TW-1:0] T_LAST   = TW'(3*DIM-3);
   localparam logic [RW-1:0] ROW_LAST = RW'(DIM-1);

   state_t        state_r, state_s;
   logic [TW-1:0] t_r, t_s;
   logic [RW-1:0] row_r, row_s;

   // Row r (and column r) carries a real element k = t - r while 0 <= t - r < DIM.
   function automatic logic [DIM-1:0] mask_of(input logic [TW-1:0] t);
      logic [DIM-1:0] m;
      int             tv;
      tv = int'(t);
      m  = '0;
      for (int r = 0; r < DIM; r++) begin
         m[r] = (tv >= r) && ((tv - r) < DIM);
      end
      return m;
   endfunction

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         t_r     <= '0;
         row_r   <= '0;
      end else begin
         state_r <= state_s;
         t_r     <= t_s;
         row_r   <= row_s;
      end
   end

   // Next-state and counter update; t saturates at its exit value, row stops at DIM-1.
   always_comb begin
      state_s = state_r;
      t_s     = t_r;
      row_s   = row_r;
      case (state_r)
         IDLE: begin
            t_s   = '0;
            row_s = '0;
            if (start) begin
               state_s = LOAD;
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            t_s     = '0;
            state_s = FEED;
         end
         FEED: begin
            if (hold) begin
               t_s = t_r;
            end else if (t_r == T_LAST) begin
               state_s = DRAIN;
               row_s   = '0;
            end else begin
               t_s = t_r + TW'(1);
            end
         end
         DRAIN: begin
            if (row_r == ROW_LAST) begin
               state_s = DONE;
            end else begin
               row_s = row_r + RW'(1);
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Output decode; mac_en in FEED follows ~hold so a stalled cycle never accumulates.
   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      mac_en     = 1'b0;
      mac_wren   = 1'b0;
      feed_t     = '0;
      feed_mask  = '0;
      c_rd_row   = '0;
      c_rd_valid = 1'b0;
      case (state_r)
         IDLE: begin
            busy = 1'b0;
         end
         LOAD: begin
            busy     = 1'b1;
            mac_en   = 1'b1;
            mac_wren = 1'b1;
         end
         FEED: begin
            busy      = 1'b1;
            mac_en    = ~hold;
            feed_t    = t_r;
            feed_mask = mask_of(t_r);
         end
         DRAIN: begin
            busy       = 1'b1;
            c_rd_valid = 1'b1;
            c_rd_row   = row_r;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mac_array_seq.sv
// Directed bench for mac_array_seq (DIM=4), including a behavioural 4x4 tpumac array
// with edge skew to check the product it sequences.
module tb_mac_array_seq;

   localparam int DIM = 4;
   localparam int TW  = 4;
   localparam int RW  = 2;
   localparam logic [3:0] MASK_TBL [10] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                                            4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           hold = 1'b0;
   logic           busy, done, mac_en, mac_wren, c_rd_valid;
   logic [TW-1:0]  feed_t;
   logic [DIM-1:0] feed_mask;
   logic [RW-1:0]  c_rd_row;
   logic [4:0]     flags;

   int n_cmp = 0;
   int n_bad = 0;

   int a_m [DIM][DIM];
   int b_m [DIM][DIM];
   int acc [DIM][DIM];
   int a_q [DIM][DIM];
   int b_q [DIM][DIM];
   int ain [DIM][DIM];
   int bin [DIM][DIM];

   mac_array_seq #(.DIM(DIM), .TW(TW), .RW(RW)) dut (
      .clk(clk), .rst(rst), .start(start), .hold(hold),
      .busy(busy), .done(done), .mac_en(mac_en), .mac_wren(mac_wren),
      .feed_t(feed_t), .feed_mask(feed_mask), .c_rd_row(c_rd_row), .c_rd_valid(c_rd_valid)
   );

   assign flags = {busy, mac_en, mac_wren, c_rd_valid, done};

   always #5 clk = ~clk;

   // Edge skew: row r gets A[r][t-r], column c gets B[t-c][c]; inner cells take neighbours' registers.
   always_comb begin
      for (int r = 0; r < DIM; r++) begin
         for (int c = 0; c < DIM; c++) begin
            ain[r][c] = 0;
            bin[r][c] = 0;
            if (c == 0) begin
               if (feed_mask[r]) ain[r][c] = a_m[r][int'(feed_t) - r];
            end else begin
               ain[r][c] = a_q[r][c-1];
            end
            if (r == 0) begin
               if (feed_mask[c]) bin[r][c] = b_m[int'(feed_t) - c][c];
            end else begin
               bin[r][c] = b_q[r-1][c];
            end
         end
      end
   end

   // tpumac cells: WrEn loads Cin=0, otherwise accumulate and pass operands on.
   always_ff @(posedge clk or posedge rst) begin
      for (int r = 0; r < DIM; r++) begin
         for (int c = 0; c < DIM; c++) begin
            if (rst) begin
               acc[r][c] <= 0;
               a_q[r][c] <= 0;
               b_q[r][c] <= 0;
            end else if (mac_en) begin
               acc[r][c] <= mac_wren ? 0 : acc[r][c] + ain[r][c] * bin[r][c];
               a_q[r][c] <= ain[r][c];
               b_q[r][c] <= bin[r][c];
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++;
      if ({flags, feed_t, feed_mask, c_rd_row} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b/%h/%b/%0d want all zero", flags, feed_t, feed_mask, c_rd_row);
      end
      #10 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         n_cmp++;
         if (flags !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_idle cyc%0d: got flags %b want 00000", i, flags);
         end
      end
   endtask

   // Full unstalled run; hold_out drives hold during LOAD and DRAIN, which must not matter.
   task automatic test_single_run(input bit hold_out);
      int busy_cnt;
      busy_cnt = 0;
      hold = hold_out;
      start = 1'b1;
      cyc();
      start = 1'b0;
      #1;
      n_cmp++;
      if (flags !== 5'b11100 || feed_t !== 4'd0) begin
         n_bad++;
         $display("FAIL load (hold=%0d): got flags %b t %0d want 11100 t 0", hold_out, flags, feed_t);
      end
      busy_cnt += int'(busy);
      hold = 1'b0;
      for (int t = 0; t < 10; t++) begin
         cyc();
         n_cmp++;
         if (flags !== 5'b11000 || feed_t !== 4'(t) || feed_mask !== MASK_TBL[t]) begin
            n_bad++;
            $display("FAIL feed t%0d: got flags %b t %0d mask %b want 11000 t %0d mask %b",
                     t, flags, feed_t, feed_mask, t, MASK_TBL[t]);
         end
         busy_cnt += int'(busy);
      end
      for (int r = 0; r < DIM; r++) begin
         cyc();
         hold = hold_out;
         #1;
         n_cmp++;
         if (flags !== 5'b10010 || c_rd_row !== 2'(r) || feed_t !== 4'd0 || feed_mask !== 4'd0) begin
            n_bad++;
            $display("FAIL drain row%0d: got flags %b row %0d t %0d want 10010 row %0d t 0",
                     r, flags, c_rd_row, feed_t, r);
         end
         busy_cnt += int'(busy);
      end
      cyc();
      n_cmp++;
      if (flags !== 5'b00001) begin
         n_bad++;
         $display("FAIL done_pulse: got flags %b want 00001", flags);
      end
      cyc();
      n_cmp++;
      if (flags !== 5'b00000) begin
         n_bad++;
         $display("FAIL back_to_idle: got flags %b want 00000", flags);
      end
      hold = 1'b0;
      n_cmp++;
      if (busy_cnt !== 15) begin
         n_bad++;
         $display("FAIL busy_len: got %0d want 15", busy_cnt);
      end
   endtask

   task automatic test_hold();
      int  busy_cnt;
      bit  seen_done;
      busy_cnt = 1;
      seen_done = 1'b0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int t = 0; t < 6; t++) begin
         cyc();
         if (t < 5) busy_cnt += int'(busy);
      end
      for (int h = 0; h < 3; h++) begin
         hold = 1'b1;
         #1;
         n_cmp++;
         if (mac_en !== 1'b0 || feed_t !== 4'd5 || feed_mask !== 4'b1100 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_cyc%0d: got en %b t %0d mask %b want en 0 t 5 mask 1100",
                     h, mac_en, feed_t, feed_mask);
         end
         busy_cnt += int'(busy);
         cyc();
      end
      hold = 1'b0;
      #1;
      n_cmp++;
      if (mac_en !== 1'b1 || feed_t !== 4'd5) begin
         n_bad++;
         $display("FAIL hold_release: got en %b t %0d want en 1 t 5", mac_en, feed_t);
      end
      busy_cnt += int'(busy);
      cyc();
      n_cmp++;
      if (feed_t !== 4'd6 || feed_mask !== 4'b1000) begin
         n_bad++;
         $display("FAIL hold_resume: got t %0d mask %b want t 6 mask 1000", feed_t, feed_mask);
      end
      busy_cnt += int'(busy);
      for (int i = 0; i < 40 && !seen_done; i++) begin
         cyc();
         if (done) seen_done = 1'b1;
         else busy_cnt += int'(busy);
      end
      n_cmp++;
      if (!seen_done || busy_cnt !== 18) begin
         n_bad++;
         $display("FAIL hold_busy_len: got %0d (done seen %0d) want 18", busy_cnt, seen_done);
      end
      cyc();
   endtask

   task automatic test_async_reset();
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int t = 0; t < 7; t++) cyc();
      n_cmp++;
      if (feed_t !== 4'd6) begin
         n_bad++;
         $display("FAIL pre_reset_t: got %0d want 6", feed_t);
      end
      #3 rst = 1'b1;
      #1;
      n_cmp++;
      if ({flags, feed_t, feed_mask, c_rd_row} !== '0) begin
         n_bad++;
         $display("FAIL async_reset: got %b/%h/%b/%0d want all zero", flags, feed_t, feed_mask, c_rd_row);
      end
      #2 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         n_cmp++;
         if (flags !== 5'b00000 || feed_t !== 4'd0) begin
            n_bad++;
            $display("FAIL post_reset_idle cyc%0d: got flags %b t %0d want 00000 t 0", i, flags, feed_t);
         end
      end
      test_single_run(1'b0);
   endtask

   task automatic test_start_ignored();
      int busy_cnt;
      bit seen_done;
      busy_cnt = 1;
      seen_done = 1'b0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 3; i++) cyc();
      start = 1'b1;
      busy_cnt += 3;
      for (int i = 0; i < 40 && !seen_done; i++) begin
         cyc();
         start = 1'b0;
         if (done) seen_done = 1'b1;
         else busy_cnt += int'(busy);
      end
      n_cmp++;
      if (!seen_done || busy_cnt !== 15) begin
         n_bad++;
         $display("FAIL start_in_feed: got busy %0d (done seen %0d) want 15", busy_cnt, seen_done);
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (flags !== 5'b00000) begin
            n_bad++;
            $display("FAIL start_in_done cyc%0d: got flags %b want 00000", i, flags);
         end
         cyc();
      end
      start = 1'b1;
      for (int run = 0; run < 2; run++) begin
         for (int i = 0; i < 17; i++) begin
            cyc();
            n_cmp++;
            if (busy !== (i < 15)) begin
               n_bad++;
               $display("FAIL start_held run%0d cyc%0d: got busy %b want %b", run, i, busy, i < 15);
            end
         end
      end
      start = 1'b0;
      cyc();
   endtask

   task automatic test_matmul(input bit ident);
      bit seen;
      int exp_v;
      seen = 1'b0;
      for (int r = 0; r < DIM; r++) begin
         for (int c = 0; c < DIM; c++) begin
            a_m[r][c] = ident ? int'(r == c) : 1;
            b_m[r][c] = r + c;
         end
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         cyc();
         if (c_rd_valid) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL matmul_drain_timeout: got no c_rd_valid want drain");
      end
      for (int r = 0; r < DIM; r++) begin
         for (int c = 0; c < DIM; c++) begin
            exp_v = ident ? (r + c) : (6 + 4 * c);
            n_cmp++;
            if (acc[c_rd_row][c] !== exp_v || c_rd_row !== 2'(r)) begin
               n_bad++;
               $display("FAIL matmul ident=%0d C[%0d][%0d]: got %0d (row %0d) want %0d",
                        ident, r, c, acc[c_rd_row][c], c_rd_row, exp_v);
            end
         end
         cyc();
      end
      cyc();
   endtask

   initial begin
      for (int r = 0; r < DIM; r++) begin
         for (int c = 0; c < DIM; c++) begin
            a_m[r][c] = 0;
            b_m[r][c] = 0;
         end
      end
      test_reset();
      test_single_run(1'b0);
      test_hold();
      test_async_reset();
      test_start_ignored();
      test_matmul(1'b0);
      test_matmul(1'b1);
      test_single_run(1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
